// File: rtl/fpga_ce_prescaler_if.sv
// Control/status bundle of the clock-enable prescaler.
// The master drives run/mode/ratio and reads back the enable, busy flag and phase.
interface fpga_ce_prescaler_if #(
  parameter int unsigned CNT_W = 8
);

  logic             run_i;
  logic             oneshot_i;
  logic [CNT_W-1:0] div_i;
  logic             load_i;
  logic             E_o;
  logic             busy_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    output run_i,
    output oneshot_i,
    output div_i,
    output load_i,
    input  E_o,
    input  busy_o,
    input  cnt_o
  );

  modport slave (
    input  run_i,
    input  oneshot_i,
    input  div_i,
    input  load_i,
    output E_o,
    output busy_o,
    output cnt_o
  );

endinterface

// File: rtl/fpga_ce_prescaler.sv
// Programmable clock-enable generator: one registered E_o pulse every Neff cycles,
// free-running or one-shot, with the ratio shadow-reloaded at terminal count or on load.
module fpga_ce_prescaler #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  fpga_ce_prescaler_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] div_q,   div_d;
  logic             e_q,     e_d;

  logic [CNT_W-1:0] neff_c;
  logic             tc_c;

  // A stored ratio of zero behaves as divide-by-one.
  assign neff_c = (div_q == '0) ? CNT_W'(1) : div_q;
  assign tc_c   = (cnt_q == (neff_c - CNT_W'(1)));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      e_q     <= e_d;
    end
  end

  // Load strobe overrides the state logic and never emits a pulse on its edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    e_d     = 1'b0;

    if (bus.load_i) begin
      div_d   = bus.div_i;
      cnt_d   = '0;
      state_d = bus.run_i ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.run_i) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!bus.run_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tc_c) begin
            cnt_d = '0;
            e_d   = 1'b1;
            div_d = bus.div_i;
            if (bus.oneshot_i) begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          cnt_d = '0;
          if (!bus.run_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.E_o    = e_q;
  assign bus.busy_o = (state_q == RUN);
  assign bus.cnt_o  = cnt_q;

endmodule

// File: doc/fpga_ce_prescaler.md
Name: fpga_ce_prescaler

Overview:
Programmable clock-enable generator. Emits a single-cycle enable pulse every N clock cycles, for free-running or one-shot operation. Sits directly upstream of fpga_dffer register cells and drives their clock-enable input, so slow-rate logic stays on the single system clock. Ratio changes are glitch-free: the new ratio is taken at terminal count, or immediately on an explicit load.

Parameters:
CNT_W, 8, width of divide ratio and internal counter; N range 1..2^CNT_W-1

Ports:
clk_i  input  1  system clock, rising edge
reset_ni  input  1  asynchronous reset, active low
run_i  input  1  level; 1 = generate enables, 0 = stop and clear
oneshot_i  input  1  mode; sampled at terminal count; 1 = stop after this pulse
div_i  input  CNT_W  requested divide ratio N; 0 treated as 1
load_i  input  1  single-cycle strobe; latch div_i now and restart period
E_o  output  1  registered clock-enable pulse
busy_o  output  1  1 while in RUN state
cnt_o  output  CNT_W  current phase counter value

Behaviour:
- Interface fixed: one clock clk_i; reset_ni asynchronous, active low.
- Reset (async, no clock needed): state=IDLE, cnt=0, div_q=0 (effective N=1), E_o=0, busy_o=0, cnt_o=0.
- Effective ratio Neff = (div_q==0) ? 1 : div_q.
- States: IDLE, RUN, DONE. busy_o = (state==RUN), decoded from the state register.
- Priority per edge: reset > load_i > state logic.
- load_i=1: div_q<=div_i, cnt<=0, E_o<=0, next state = run_i ? RUN : IDLE. No pulse is emitted that edge, even if a terminal count coincides.
- IDLE: cnt<=0, E_o<=0; run_i=1 -> RUN.
- RUN, run_i=0: -> IDLE, cnt<=0, E_o<=0. A partially counted period is discarded and emits no pulse.
- RUN, run_i=1, cnt!=Neff-1: cnt<=cnt+1, E_o<=0.
- RUN, run_i=1, cnt==Neff-1 (terminal count):
  - cnt<=0, E_o<=1, div_q<=div_i (shadow reload).
  - If oneshot_i=1, state -> DONE.
- DONE: E_o<=0, cnt<=0. Holds until run_i=0 -> IDLE. Re-arm requires a run_i low-then-high.
- Latency:
  - First E_o high appears on the Neff-th rising edge after the edge that entered RUN.
  - Thereafter E_o is high for exactly 1 cycle every Neff cycles.
  - Neff=1: E_o stays high every cycle while in RUN.
- div_i changes without load_i take effect only at the next terminal count. The current period always completes at the old ratio.
- oneshot_i is only sampled at terminal count; changes mid-period have no effect until then.
- Counter never exceeds Neff-1. No wrap at 2^CNT_W, because Neff <= 2^CNT_W-1.
- E_o is a pure register output with no combinational path from inputs, so it is safe to fan out to many fpga_dffer E_i pins.

Test Plan:
1. Reset, then load_i with div_i=4 and run_i=1 -> cnt_o sequence 0,1,2,3,0,1..., E_o high only in cycles where cnt_o returns to 0 (1 of every 4); first pulse on the 4th edge after RUN entry; busy_o=1.
2. div_i=0, then div_i=1, each loaded with run_i=1 -> E_o high every cycle while running; run_i=0 -> E_o=0 and busy_o=0 on the next edge.
3. Oneshot: load div_i=3, oneshot_i=1, run_i=1 -> exactly one E_o pulse 3 edges after entry, then busy_o=0 and no further pulses while run_i stays 1. Drop run_i for 1 cycle and raise it -> exactly one more pulse.
4. Ratio change, div 4 -> 2:
   - Without load_i (div_i changed at cnt_o=1): the current period still ends at cnt_o=3, later periods are 2 cycles.
   - With load_i at cnt_o=3 (coinciding with terminal count): no pulse that edge, cnt_o=0, next pulse 2 edges later.
5. run_i dropped while cnt_o=2 with div=4 -> no E_o pulse, cnt_o=0 and busy_o=0 after one edge; re-raise -> full 4-cycle period before the first pulse.
6. Assert reset_ni low between clock edges while E_o=1 and cnt_o nonzero -> E_o, busy_o and cnt_o go to 0 immediately without a clock edge. After release, the block stays IDLE with Neff=1 until run_i is raised.
